ethernet_smi_responder: RTL and testbench

Target (PHY-side) end of the Ethernet SMI/MDIO management bus: decodes Clause-22 frames clocked in on mdc/mdio by the SMI master and maps them onto a local 32x16 register-bank request interface. It services reads by turning the bus around and shifting register data out, and writes by issuing a single-cycle write strobe. It is used to model or implement a PHY management slave and for loopback test of the SMI master.

---
 rtl/ethernet_smi_responder_if.sv | 17 +
 rtl/ethernet_smi_responder.sv | 158 +++++++++++++++
 tb/tb_ethernet_smi_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_smi_responder_if.sv
// ethernet_smi_responder_if: register-bank request/response link between the SMI responder and a 32x16 register file
interface ethernet_smi_responder_if;
    logic [4:0]  reg_address;
    logic [15:0] reg_write_data;
    logic        reg_write;
    logic        reg_read;
    logic [15:0] reg_read_data;
    logic        reg_read_valid;
    modport master (
        output reg_address, reg_write_data, reg_write, reg_read,
        input  reg_read_data, reg_read_valid
    );
    modport slave (
        input  reg_address, reg_write_data, reg_write, reg_read,
        output reg_read_data, reg_read_valid
    );
endinterface

// File: rtl/ethernet_smi_responder.sv
// ethernet_smi_responder: Clause-22 SMI/MDIO target mapping frames onto a register-bank request interface
module ethernet_smi_responder #(
    parameter int PREAMBLE_MIN = 0,
    parameter bit BROADCAST_EN = 1'b1,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [4:0]                      phy_address_i,
    input  logic                            mdc_i,
    inout  wire                             mdio_io,
    ethernet_smi_responder_if.master        reg_if,
    output logic                            busy_o,
    output logic                            frame_error_o,
    output logic                            read_timeout_o
);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [6:0] PMIN = (PREAMBLE_MIN > 63) ? 7'd64 : 7'(PREAMBLE_MIN);
    typedef enum logic [2:0] {HUNT, START, HEADER, READ, WRITE, SKIP} state_t;
    state_t        state_q, state_d;
    logic [2:0]    mdc_q;
    logic [1:0]    mdio_q;
    logic [5:0]    ones_q, ones_d, cnt_q, cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [15:0]   sh_q, sh_d, rdata_q, rdata_d, wdata_q, wdata_d, eff;
    logic [4:0]    addr_q, addr_d;
    logic          got_q, got_d, oe_q, oe_d, out_q, out_d;
    logic          wr_q, wr_d, rd_q, rd_d, ferr_q, ferr_d, rto_q, rto_d;
    logic          sp, bit_i, last, match, op_ok;
    logic [15:0]   shin;
    assign sp    = mdc_q[1] & ~mdc_q[2];
    assign bit_i = mdio_q[1];
    assign shin  = {sh_q[14:0], bit_i};
    assign last  = sp && cnt_q == 6'd31;
    assign match = shin[9:5] == phy_address_i || (BROADCAST_EN && shin[9:5] == 5'd0);
    assign op_ok = shin[11] ^ shin[10];
    assign eff   = got_q ? rdata_q : 16'hFFFF;
    assign mdio_io = oe_q ? out_q : 1'bz;
    assign busy_o = state_q != HUNT;
    assign frame_error_o = ferr_q;
    assign read_timeout_o = rto_q;
    assign reg_if.reg_address = addr_q;
    assign reg_if.reg_write_data = wdata_q;
    assign reg_if.reg_write = wr_q;
    assign reg_if.reg_read = rd_q;
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        cnt_d   = sp ? cnt_q + 6'd1 : cnt_q;
        idle_d  = (state_q == HUNT || sp) ? '0 : idle_q + TW'(1);
        sh_d    = sp ? shin : sh_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        got_d   = got_q;
        oe_d    = oe_q;
        out_d   = out_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        ferr_d  = 1'b0;
        rto_d   = 1'b0;
        case (state_q)
            HUNT: if (sp) begin
                ones_d = bit_i ? ones_q + {5'd0, ones_q != 6'd63} : '0;
                if (!bit_i && {1'b0, ones_q} >= PMIN) begin
                    state_d = START;
                    cnt_d = 6'd1;
                end
            end
            START: if (sp) begin
                state_d = bit_i ? HEADER : HUNT;
                ferr_d = !bit_i;
            end
            HEADER: if (sp && cnt_q == 6'd13) begin
                state_d = !op_ok || !match ? SKIP : shin[11] ? READ : WRITE;
                ferr_d = !op_ok;
                rd_d = op_ok && match && shin[11];
                addr_d = op_ok && match ? shin[4:0] : addr_q;
                got_d = 1'b0;
            end
            READ: begin
                if (reg_if.reg_read_valid && !got_q) begin
                    got_d = 1'b1;
                    rdata_d = reg_if.reg_read_data;
                end
                // late data is replaced by all-ones and the later valid is locked out
                if (sp && cnt_q == 6'd14) begin
                    oe_d = 1'b1;
                    out_d = 1'b0;
                end else if (sp && cnt_q == 6'd15) begin
                    out_d = eff[15];
                    sh_d = {eff[14:0], 1'b0};
                    rto_d = !got_q;
                    got_d = 1'b1;
                end else if (last) begin
                    oe_d = 1'b0;
                    state_d = HUNT;
                end else if (sp && cnt_q >= 6'd16) begin
                    out_d = sh_q[15];
                    sh_d = {sh_q[14:0], 1'b0};
                end
            end
            WRITE: if (last) begin
                wr_d = 1'b1;
                wdata_d = shin;
                state_d = HUNT;
            end
            SKIP: if (last) state_d = HUNT;
            default: state_d = HUNT;
        endcase
        if (state_q != HUNT && !sp && idle_q == TW'(IDLE_TIMEOUT - 1)) begin
            state_d = HUNT;
            ferr_d = 1'b1;
            oe_d = 1'b0;
            wr_d = 1'b0;
        end
        if (state_q != HUNT && state_d == HUNT) ones_d = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            mdc_q   <= '0;
            mdio_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            got_q   <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ferr_q  <= 1'b0;
            rto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mdc_q   <= {mdc_q[1:0], mdc_i};
            mdio_q  <= {mdio_q[0], mdio_io};
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            got_q   <= got_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ferr_q  <= ferr_d;
            rto_q   <= rto_d;
        end
    end
endmodule

// File: tb/tb_ethernet_smi_responder.sv
// tb_ethernet_smi_responder: SMI master model driving two responders (no preamble / 32-bit preamble)
module tb_ethernet_smi_responder;
    localparam int H = 10;
    logic clk = 1'b0, rst = 1'b1;
    logic mdc_a = 1'b0, mdc_b = 1'b0, m_oe = 1'b0, m_val = 1'b1, sel = 1'b0;
    logic busy_a, ferr_a, rto_a, busy_b, ferr_b, rto_b;
    wire  mdio_a, mdio_b;
    pullup (mdio_a);
    pullup (mdio_b);
    assign mdio_a = (m_oe && !sel) ? m_val : 1'bz;
    assign mdio_b = (m_oe && sel) ? m_val : 1'bz;
    ethernet_smi_responder_if ifa ();
    ethernet_smi_responder_if ifb ();
    ethernet_smi_responder dut (
        .clk(clk), .rst(rst), .phy_address_i(5'd3), .mdc_i(mdc_a), .mdio_io(mdio_a),
        .reg_if(ifa), .busy_o(busy_a), .frame_error_o(ferr_a), .read_timeout_o(rto_a)
    );
    ethernet_smi_responder #(.PREAMBLE_MIN(32)) dut_p (
        .clk(clk), .rst(rst), .phy_address_i(5'd3), .mdc_i(mdc_b), .mdio_io(mdio_b),
        .reg_if(ifb), .busy_o(busy_b), .frame_error_o(ferr_b), .read_timeout_o(rto_b)
    );
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, rto_cnt = 0, wr_b_cnt = 0;
    logic [20:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [4:0]  exp_raddr = 5'd0;
    logic        rsp_on = 1'b0, stray_go = 1'b0;
    logic [15:0] rsp_data = 16'h0000;
    int          rsp_dly = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // monitors, write scoreboard and register-file responder, all away from the active edge
    always @(negedge clk) begin
        ifa.reg_read_valid = 1'b0;
        ifb.reg_read_valid = 1'b0;
        ifb.reg_read_data = 16'h0;
        if (ifa.reg_write) begin
            wr_cnt++;
            chk("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) chk("wr_addr_data", {ifa.reg_address, ifa.reg_write_data}, exp_wr.pop_front());
        end
        if (ifb.reg_write) wr_b_cnt++;
        if (ferr_a) ferr_cnt++;
        if (rto_a) rto_cnt++;
        if (rsp_dly > 0) begin
            rsp_dly--;
            if (rsp_dly == 0) begin
                ifa.reg_read_valid = 1'b1;
                ifa.reg_read_data = rsp_data;
            end
        end
        if (ifa.reg_read) begin
            rd_cnt++;
            chk("rd_addr", ifa.reg_address, exp_raddr);
            if (rsp_on) rsp_dly = 2;
        end
        if (stray_go) begin
            ifa.reg_read_valid = 1'b1;
            ifa.reg_read_data = 16'hDEAD;
        end
    end

    function automatic logic [31:0] fw(input logic [1:0] st, op, input logic [4:0] pa, ra, input logic [15:0] d);
        return {st, op, pa, ra, 2'b10, d};
    endfunction

    task automatic mdc_drv(input logic v);
        if (sel) mdc_b = v;
        else mdc_a = v;
    endtask

    task automatic frame(input logic [31:0] f, input bit rd, input int n, output logic [1:32] cap);
        cap = '1;
        for (int k = 1; k <= n; k++) begin
            mdc_drv(1'b0);
            m_oe = !(rd && k > 14);
            m_val = f[32-k];
            repeat (H) @(posedge clk);
            #1 cap[k] = sel ? mdio_b : mdio_a;
            mdc_drv(1'b1);
            repeat (H) @(posedge clk);
        end
        m_oe = 1'b0;
    endtask

    initial begin
        logic [1:32] cap;
        int w0, r0, f0, t0, b0, waited;
        ifa.reg_read_valid = 1'b0;
        ifa.reg_read_data = 16'h0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_outputs", {ifa.reg_write, ifa.reg_read, ferr_a, rto_a, ifa.reg_address, ifa.reg_write_data}, 0);
        chk("rst_mdio_released", mdio_a, 1);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // basic write
        w0 = wr_cnt; f0 = ferr_cnt;
        exp_wr.push_back({5'd5, 16'hABCD});
        frame(fw(2'b01, 2'b01, 5'd3, 5'd5, 16'hABCD), 0, 32, cap);
        repeat (4) @(negedge clk);
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_no_ferr", ferr_cnt - f0, 0);
        chk("wr_idle_busy", busy_a, 0);

        // read with data two clocks after the request
        r0 = rd_cnt; t0 = rto_cnt;
        rsp_on = 1'b1; rsp_data = 16'h1234; exp_raddr = 5'd5;
        exp_rd.push_back(16'h1234);
        frame(fw(2'b01, 2'b10, 5'd3, 5'd5, 16'h0), 1, 32, cap);
        @(negedge clk);
        chk("rd_ta1_released", cap[15], 1);
        chk("rd_ta2_zero", cap[16], 0);
        chk("rd_data", cap[17:32], exp_rd.pop_front());
        chk("rd_released_after", mdio_a, 1);
        chk("rd_count", rd_cnt - r0, 1);
        chk("rd_no_timeout", rto_cnt - t0, 0);

        // stray valid outside a read, then read with no data
        stray_go = 1'b1;
        @(negedge clk);
        stray_go = 1'b0;
        rsp_on = 1'b0; exp_raddr = 5'd9; t0 = rto_cnt;
        exp_rd.push_back(16'hFFFF);
        frame(fw(2'b01, 2'b10, 5'd3, 5'd9, 16'h0), 1, 32, cap);
        @(negedge clk);
        chk("rto_data", cap[17:32], exp_rd.pop_front());
        chk("rto_pulse", rto_cnt - t0, 1);

        // address mismatch (write and read) then broadcast
        w0 = wr_cnt; r0 = rd_cnt;
        frame(fw(2'b01, 2'b01, 5'd7, 5'd5, 16'h1111), 0, 32, cap);
        frame(fw(2'b01, 2'b10, 5'd7, 5'd5, 16'h0), 1, 32, cap);
        @(negedge clk);
        chk("mismatch_no_wr", wr_cnt - w0, 0);
        chk("mismatch_no_rd", rd_cnt - r0, 0);
        chk("mismatch_never_driven", cap[15:32], 18'h3FFFF);
        exp_wr.push_back({5'd6, 16'h2222});
        frame(fw(2'b01, 2'b01, 5'd0, 5'd6, 16'h2222), 0, 32, cap);
        repeat (4) @(negedge clk);
        chk("bcast_wr", wr_cnt - w0, 1);

        // bad ST, bad OP, then back-to-back valid frame
        f0 = ferr_cnt; w0 = wr_cnt;
        frame(32'h0, 0, 2, cap);
        repeat (6) @(negedge clk);
        chk("bad_st_ferr", ferr_cnt - f0, 1);
        chk("bad_st_busy", busy_a, 0);
        frame(fw(2'b01, 2'b11, 5'd3, 5'd5, 16'h3333), 0, 32, cap);
        chk("bad_op_ferr", ferr_cnt - f0, 2);
        exp_wr.push_back({5'd9, 16'h5A5A});
        frame(fw(2'b01, 2'b01, 5'd3, 5'd9, 16'h5A5A), 0, 32, cap);
        repeat (4) @(negedge clk);
        chk("b2b_wr", wr_cnt - w0, 1);
        chk("b2b_no_ferr", ferr_cnt - f0, 2);

        // preamble length on the PREAMBLE_MIN=32 instance
        sel = 1'b1; b0 = wr_b_cnt;
        frame(32'hFFFF_FFFF, 0, 31, cap);
        frame(fw(2'b01, 2'b01, 5'd3, 5'd4, 16'h5AA0), 0, 32, cap);
        repeat (4) @(negedge clk);
        chk("pre31_ignored", wr_b_cnt - b0, 0);
        frame(32'hFFFF_FFFF, 0, 32, cap);
        frame(fw(2'b01, 2'b01, 5'd3, 5'd4, 16'h1357), 0, 32, cap);
        repeat (4) @(negedge clk);
        chk("pre32_accepted", wr_b_cnt - b0, 1);
        chk("pre32_data", {ifb.reg_address, ifb.reg_write_data}, {5'd4, 16'h1357});
        sel = 1'b0;

        // mdc stops mid-write
        f0 = ferr_cnt; w0 = wr_cnt;
        frame(fw(2'b01, 2'b01, 5'd3, 5'd2, 16'h4444), 0, 20, cap);
        repeat (900) @(negedge clk);
        chk("to_not_early", ferr_cnt - f0, 0);
        chk("to_busy_held", busy_a, 1);
        waited = 0;
        while (ferr_cnt == f0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("to_ferr", ferr_cnt - f0, 1);
        chk("to_no_wr", wr_cnt - w0, 0);
        chk("to_busy_clear", busy_a, 0);

        // reset in the middle of a read while driving zeros
        rsp_on = 1'b1; rsp_data = 16'h0000; exp_raddr = 5'd1;
        w0 = wr_cnt; r0 = rd_cnt; t0 = rto_cnt;
        frame(fw(2'b01, 2'b10, 5'd3, 5'd1, 16'h0), 1, 20, cap);
        @(negedge clk);
        chk("mid_rd_driving", mdio_a, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_released", mdio_a, 1);
        chk("mid_rst_busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_strobes", {wr_cnt - w0, rd_cnt - r0, rto_cnt - t0}, {32'd0, 32'd1, 32'd0});

        // recovery
        rsp_on = 1'b0;
        exp_wr.push_back({5'd31, 16'h0F0F});
        frame(fw(2'b01, 2'b01, 5'd3, 5'd31, 16'h0F0F), 0, 32, cap);
        repeat (4) @(negedge clk);
        chk("recover_wr", wr_cnt - w0, 1);
        chk("sb_drained", exp_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
